// File: rtl/timer_display_scan_pkg.sv
// Shared constants for the timer display: digit count and active-low
// seven-segment patterns, ordered {g,f,e,d,c,b,a}.
package timer_pkg;
  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 9 is the leftmost entry, index 0 the rightmost.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/timer_display_scan_seg7_decode.sv
// Combinational digit decoder: values above max_digit_i render as a dash.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [5:0] value_i,
  input  logic [3:0] max_digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (value_i <= {2'b00, max_digit_i}) begin
      seg_o = SEG_DIGITS[value_i[3:0]];
    end
  end

endmodule

// File: rtl/timer_display_scan.sv
// Three-digit multiplexed m:ss display with per-frame input snapshot,
// ghost-guard cycle at each slot start and pause blinking.
module timer_display_scan
  import timer_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            seconds0,
  input  logic [5:0]            seconds1,
  input  logic [5:0]            minutes0,
  input  logic                  enable,
  input  logic                  pause,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [5:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d;
  logic [9:0]    frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          slot_end, frame_end;
  logic [5:0]    dec_val;
  logic [3:0]    dec_max;

  always_comb begin
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (slot_q == 2'd2);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;

    slot_d = slot_q;
    if (slot_end) begin
      slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end

    s0_d = s0_q;
    s1_d = s1_q;
    m0_d = m0_q;
    if (frame_end) begin
      s0_d = seconds0;
      s1_d = seconds1;
      m0_d = minutes0;
    end

    // Held at zero while not paused, so a new pause always starts visible.
    frame_d = frame_q;
    blink_d = blink_q;
    if (!pause) begin
      frame_d = '0;
      blink_d = 1'b0;
    end else if (frame_end) begin
      if (frame_q == 10'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 10'd1;
      end
    end

    // Decode what the next cycle's slot will show, so seg tracks slot_q.
    case (slot_d)
      2'd0:    begin dec_val = s0_d; dec_max = 4'd9; end
      2'd1:    begin dec_val = s1_d; dec_max = 4'd5; end
      default: begin dec_val = m0_d; dec_max = 4'd9; end
    endcase
    dp_d = (slot_d != 2'd2);
  end

  seg7_decode u_decode (
    .value_i    (dec_val),
    .max_digit_i(dec_max),
    .seg_o      (seg_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      slot_q  <= 2'd0;
      s0_q    <= '0;
      s1_q    <= '0;
      m0_q    <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      m0_q    <= m0_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    an = '1;
    if (enable && !(pause && blink_q) && (cnt_q != '0)) begin
      case (slot_q)
        2'd0:    an[0] = 1'b0;
        2'd1:    an[1] = 1'b0;
        2'd2:    an[2] = 1'b0;
        default: an = '1;
      endcase
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q | ~enable;

endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized bench for timer_display_scan: a time-based reference model
// predicts every cycle's {an, seg, dp}; a negedge monitor compares.
module tb_timer_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 3 * SCAN_DIV;

  logic       clk;
  logic       reset;
  logic [5:0] seconds0, seconds1, minutes0;
  logic       enable, pause;
  logic [6:0] seg;
  logic [2:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  timer_display_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .seconds0(seconds0),
    .seconds1(seconds1),
    .minutes0(minutes0),
    .enable  (enable),
    .pause   (pause),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: n = clock edges since reset release
  int         n;
  int         paused_frames;
  logic [5:0] sh [3];

  function automatic logic [6:0] ref_digit(input int v, input int maxd);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > maxd) return 7'b0111111;
    return tbl[v];
  endfunction

  function automatic logic model_dark_phase();
    return pause && (((paused_frames / BLINK_FRAMES) % 2) == 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0;
      paused_frames = 0;
      sh[0] = '0;
      sh[1] = '0;
      sh[2] = '0;
    end else begin
      if ((n % FRAME_LEN) == FRAME_LEN - 1) begin
        sh[0] = seconds0;
        sh[1] = seconds1;
        sh[2] = minutes0;
      end
      if (!pause) paused_frames = 0;
      else if ((n % FRAME_LEN) == FRAME_LEN - 1) paused_frames++;
      n++;
    end
  end

  function automatic logic [10:0] model_out();
    int slot, phase;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (!reset) return {3'b111, 7'b1111111, 1'b1};
    slot  = (n / SCAN_DIV) % 3;
    phase = n % SCAN_DIV;
    e_an  = 3'b111;
    if (enable && !model_dark_phase() && phase != 0) e_an = ~(3'b001 << slot);
    if (n == 0) begin
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
    end else begin
      e_seg = ref_digit(int'(sh[slot]), (slot == 1) ? 5 : 9);
      e_dp  = (slot == 2) ? 1'b0 : 1'b1;
    end
    if (!enable) e_dp = 1'b1;
    return {e_an, e_seg, e_dp};
  endfunction

  // Scoreboard: expectation pushed after inputs settle, popped at negedge
  logic [10:0] exp_q[$];

  always @(posedge clk) begin
    #3;
    exp_q.push_back(model_out());
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t n=%0d: got %b expected %b", name, $time, n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("an",  {4'b0, an}, {4'b0, e[10:8]});
      check("seg", seg, e[7:1]);
      check("dp",  {6'b0, dp}, {6'b0, e[0]});
    end
  end

  // Driver
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic set_digits(input int s0, input int s1, input int m0);
    seconds0 = 6'(s0);
    seconds1 = 6'(s1);
    minutes0 = 6'(m0);
  endtask

  initial begin
    reset = 1'b1;
    set_digits(0, 0, 0);
    enable = 1'b1;
    pause  = 1'b0;
    #1 reset = 1'b0;
    step(2);
    reset = 1'b1;

    // Scan pattern with zero inputs
    step(3 * FRAME_LEN);

    // Snapshot: change inputs mid-frame twice
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(5);
    set_digits(5, 3, 2);
    step(FRAME_LEN);
    set_digits(7, 4, 1);
    step(3 * FRAME_LEN);

    // Out-of-range digits
    set_digits(12, 6, 9);
    step(2 * FRAME_LEN);
    set_digits(63, 63, 10);
    step(2 * FRAME_LEN);
    set_digits(9, 5, 9);

    // Blink for 8 frames, then drop pause while dark
    pause = 1'b1;
    step(8 * FRAME_LEN);
    begin
      int waited = 0;
      while (!model_dark_phase() && waited < 10 * FRAME_LEN) begin
        step(1);
        waited++;
      end
      checks++;
      if (!model_dark_phase()) begin
        errors++;
        $display("FAIL blink_dark_wait: dark phase not reached within %0d cycles", waited);
      end
    end
    step(3);
    pause = 1'b0;
    step(2 * FRAME_LEN);

    // Enable off keeps scanning; reset pulse mid-slot
    enable = 1'b0;
    step(2 * FRAME_LEN + 5);
    enable = 1'b1;
    step(6);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2 * FRAME_LEN);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(1, 20));
      set_digits($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pause = ~pause;
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b0;
        step($urandom_range(1, 3));
        reset = 1'b1;
      end
    end

    step(4);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
